// File: rtl/effect_chain_xfade.sv
// Serial effect chain: each slot crossfades an external effect return against a latency-matched dry copy.
// Optional build macro EFFECT_CHAIN_LATCHK_EN adds sticky per-slot return-latency mismatch flags.
module effect_chain_xfade #(
  parameter int NUM_SLOTS    = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int SLOT_LATENCY = 7,
  parameter int GAIN_WIDTH   = 8,
  parameter int RAMP_STEP    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sample_valid,
  input  logic [DATA_WIDTH-1:0]           audio_in,
  input  logic [NUM_SLOTS-1:0]            slot_enable,
  output logic [NUM_SLOTS-1:0]            send_valid,
  output logic [NUM_SLOTS*DATA_WIDTH-1:0] send_data,
  input  logic [NUM_SLOTS-1:0]            return_valid,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0] return_data,
  output logic [NUM_SLOTS-1:0]            slot_wet,
  output logic [NUM_SLOTS-1:0]            latency_err,
  output logic [DATA_WIDTH-1:0]           audio_out,
  output logic                            audio_out_valid
);

  localparam int MIX_W = DATA_WIDTH + GAIN_WIDTH + 2;
  localparam int FULL  = 1 << GAIN_WIDTH;

  localparam logic [GAIN_WIDTH:0]   FULL_G = (GAIN_WIDTH+1)'(FULL);
  localparam logic [GAIN_WIDTH+1:0] FULL_U = (GAIN_WIDTH+2)'(FULL);
  localparam logic [GAIN_WIDTH:0]   STEP_G = (GAIN_WIDTH+1)'(RAMP_STEP);
  localparam logic [GAIN_WIDTH+1:0] STEP_U = (GAIN_WIDTH+2)'(RAMP_STEP);

  localparam logic [1:0] ST_DRY  = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_WET  = 2'd2;
  localparam logic [1:0] ST_DOWN = 2'd3;

  logic [NUM_SLOTS-1:0][DATA_WIDTH-1:0] slot_data;
  logic [NUM_SLOTS-1:0]                 slot_valid;

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;

    if (k == 0) begin : g_head
      assign in_data  = audio_in;
      assign in_valid = sample_valid;
    end else begin : g_link
      assign in_data  = slot_data[k-1];
      assign in_valid = slot_valid[k-1];
    end

    assign send_data[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
    assign send_valid[k] = in_valid;

    logic [SLOT_LATENCY-1:0][DATA_WIDTH-1:0] dly_data, dly_data_nx;
    logic [SLOT_LATENCY-1:0]                 dly_valid, dly_valid_nx;

    if (SLOT_LATENCY > 1) begin : g_deep
      assign dly_data_nx  = {dly_data[SLOT_LATENCY-2:0], in_data};
      assign dly_valid_nx = {dly_valid[SLOT_LATENCY-2:0], in_valid};
    end else begin : g_single
      assign dly_data_nx  = in_data;
      assign dly_valid_nx = in_valid;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dly_data  <= '0;
        dly_valid <= '0;
      end else begin
        dly_data  <= dly_data_nx;
        dly_valid <= dly_valid_nx;
      end
    end

    logic signed [DATA_WIDTH-1:0] dry, wet;
    logic                         dry_valid;

    assign dry       = dly_data[SLOT_LATENCY-1];
    assign dry_valid = dly_valid[SLOT_LATENCY-1];
    assign wet       = return_data[k*DATA_WIDTH +: DATA_WIDTH];

    logic [1:0]            state, state_nx;
    logic [GAIN_WIDTH:0]   gain, gain_nx;
    logic [GAIN_WIDTH+1:0] up_sum;

    // Next gain follows the enable level directly; the state only names where the ramp sits.
    always_comb begin
      up_sum = {1'b0, gain} + STEP_U;
      if (slot_enable[k]) begin
        gain_nx  = (up_sum >= FULL_U) ? FULL_G : up_sum[GAIN_WIDTH:0];
        state_nx = (gain_nx == FULL_G) ? ST_WET : ST_UP;
      end else begin
        gain_nx  = (gain <= STEP_G) ? '0 : gain - STEP_G;
        state_nx = (gain_nx == '0) ? ST_DRY : ST_DOWN;
      end
    end

    logic signed [MIX_W-1:0] wet_x, dry_x, g_x, gc_x, acc;
    logic [DATA_WIDTH-1:0]   mix;

    always_comb begin
      wet_x = MIX_W'(wet);
      dry_x = MIX_W'(dry);
      g_x   = MIX_W'(gain);
      gc_x  = MIX_W'(FULL_G - gain);
      acc   = wet_x * g_x + dry_x * gc_x;
      mix   = DATA_WIDTH'(acc >>> GAIN_WIDTH);
    end

    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;

    // The triggering sample is mixed with the current gain; the update lands for the next one.
    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= ST_DRY;
        gain      <= '0;
        out_data  <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= dry_valid;
        if (dry_valid) begin
          out_data <= mix;
          gain     <= gain_nx;
          state    <= state_nx;
        end
      end
    end

    assign slot_data[k]  = out_data;
    assign slot_valid[k] = out_valid;
    assign slot_wet[k]   = (state == ST_WET);

`ifdef EFFECT_CHAIN_LATCHK_EN
    logic lat_err;

    always_ff @(posedge clk) begin
      if (rst) begin
        lat_err <= 1'b0;
      end else if (return_valid[k] != dry_valid) begin
        lat_err <= 1'b1;
      end
    end

    assign latency_err[k] = lat_err;
`else
    assign latency_err[k] = 1'b0;
`endif
  end

`ifndef EFFECT_CHAIN_LATCHK_EN
  logic unused_return_valid;
  assign unused_return_valid = ^return_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      audio_out       <= '0;
      audio_out_valid <= 1'b0;
    end else begin
      audio_out       <= slot_data[NUM_SLOTS-1];
      audio_out_valid <= slot_valid[NUM_SLOTS-1];
    end
  end

endmodule
